// File: rtl/demux_1_to_15_loader_pkg.sv
// Shared definitions for the 15-way tap loader.
//   NUM_TAPS   number of output registers (fixed at 15)
//   SEL_W      width of register index / burst counter
//   SEL_UNUSED unused select code (no register written)
//   LAST_IDX   index of the final burst word
//   state_e    loader FSM states
package rc_pkg;

  localparam int unsigned NUM_TAPS = 15;
  localparam int unsigned SEL_W    = 4;

  localparam logic [SEL_W-1:0] SEL_UNUSED = 4'hF;
  localparam logic [SEL_W-1:0] LAST_IDX   = 4'd14;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_LOAD = 1'b1
  } state_e;

endpackage

// File: rtl/demux_1_to_15_loader_if.sv
// Control/data bundle for demux_1_to_15_loader.
//   master : source side (drives start/abort/burst word/single write)
//   slave  : loader side (drives in_ready/busy/done/load_cnt)
interface demux_1_to_15_loader_if
  import rc_pkg::*;
#(
  parameter int unsigned SIZE = 16
) ();

  logic             start;
  logic             abort;
  logic             in_valid;
  logic [SIZE-1:0]  in_data;
  logic             in_ready;
  logic             wr_en;
  logic [SEL_W-1:0] wr_sel;
  logic [SIZE-1:0]  wr_data;
  logic             busy;
  logic             done;
  logic [SEL_W-1:0] load_cnt;

  modport master (
    output start, abort, in_valid, in_data, wr_en, wr_sel, wr_data,
    input  in_ready, busy, done, load_cnt
  );

  modport slave (
    input  start, abort, in_valid, in_data, wr_en, wr_sel, wr_data,
    output in_ready, busy, done, load_cnt
  );

endinterface

// File: rtl/demux_1_to_15_loader_bank.sv
// tap_reg_bank: 15 x SIZE registers with one synchronous write port.
//   clk, rst : clock, synchronous active-high reset (clears all registers)
//   we_i     : write enable
//   idx_i    : register index; codes >= NUM_TAPS write nothing
//   data_i   : write data
//   q_o      : all register contents
module tap_reg_bank
  import rc_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               we_i,
  input  logic [SEL_W-1:0]                   idx_i,
  input  logic [SIZE-1:0]                    data_i,
  output logic [NUM_TAPS-1:0][SIZE-1:0]      q_o
);

  logic [NUM_TAPS-1:0][SIZE-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
        if (we_i && (idx_i == SEL_W'(i))) begin
          regs_q[i] <= data_i;
        end
      end
    end
  end

  assign q_o = regs_q;

endmodule

// File: rtl/demux_1_to_15_loader.sv
// demux_1_to_15_loader: distributes a SIZE-bit stream into 15 registers B0..B14,
// either as an ordered 15-word burst (valid/ready) or as single addressed writes.
//   clk, rst : clock, synchronous active-high reset
//   bus      : start/abort, burst handshake, single write, busy/done/load_cnt
//   B0..B14  : registered outputs
module demux_1_to_15_loader
  import rc_pkg::*;
#(
  parameter int unsigned SIZE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  demux_1_to_15_loader_if.slave bus,
  output logic [SIZE-1:0]      B0,
  output logic [SIZE-1:0]      B1,
  output logic [SIZE-1:0]      B2,
  output logic [SIZE-1:0]      B3,
  output logic [SIZE-1:0]      B4,
  output logic [SIZE-1:0]      B5,
  output logic [SIZE-1:0]      B6,
  output logic [SIZE-1:0]      B7,
  output logic [SIZE-1:0]      B8,
  output logic [SIZE-1:0]      B9,
  output logic [SIZE-1:0]      B10,
  output logic [SIZE-1:0]      B11,
  output logic [SIZE-1:0]      B12,
  output logic [SIZE-1:0]      B13,
  output logic [SIZE-1:0]      B14
);

  state_e           state_q, state_d;
  logic [SEL_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;

  logic             we;
  logic [SEL_W-1:0] idx;
  logic [SIZE-1:0]  wdata;

  logic [NUM_TAPS-1:0][SIZE-1:0] regs;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  // Single write port: burst words own it in LOAD, addressed writes in IDLE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    we      = 1'b0;
    idx     = cnt_q;
    wdata   = bus.in_data;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.wr_en && (bus.wr_sel != SEL_UNUSED)) begin
          we    = 1'b1;
          idx   = bus.wr_sel;
          wdata = bus.wr_data;
        end
        if (bus.start) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      ST_LOAD: begin
        if (bus.in_valid) begin
          we    = 1'b1;
          idx   = cnt_q;
          wdata = bus.in_data;
          if (cnt_q == LAST_IDX) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        // Abort still lets a coincident word land (write above) but never pulses done.
        if (bus.abort) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign bus.in_ready = (state_q == ST_LOAD);
  assign bus.busy     = (state_q == ST_LOAD);
  assign bus.done     = done_q;
  assign bus.load_cnt = cnt_q;

  tap_reg_bank #(
    .SIZE (SIZE)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .we_i   (we),
    .idx_i  (idx),
    .data_i (wdata),
    .q_o    (regs)
  );

  assign B0  = regs[0];
  assign B1  = regs[1];
  assign B2  = regs[2];
  assign B3  = regs[3];
  assign B4  = regs[4];
  assign B5  = regs[5];
  assign B6  = regs[6];
  assign B7  = regs[7];
  assign B8  = regs[8];
  assign B9  = regs[9];
  assign B10 = regs[10];
  assign B11 = regs[11];
  assign B12 = regs[12];
  assign B13 = regs[13];
  assign B14 = regs[14];

endmodule

// File: tb/tb_demux_1_to_15_loader.sv
// Testbench for demux_1_to_15_loader: scenario tasks with a register-image model.
module tb_demux_1_to_15_loader;

  typedef logic [15:0] word_arr_t [15];

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  demux_1_to_15_loader_if #(.SIZE(16)) bus ();

  logic [15:0] bo [15];
  logic [15:0] exp_b [15];
  int total = 0;
  int bad = 0;

  demux_1_to_15_loader #(.SIZE(16)) dut (
    .clk (clk), .rst (rst), .bus (bus.slave),
    .B0 (bo[0]),   .B1 (bo[1]),   .B2 (bo[2]),   .B3 (bo[3]),   .B4 (bo[4]),
    .B5 (bo[5]),   .B6 (bo[6]),   .B7 (bo[7]),   .B8 (bo[8]),   .B9 (bo[9]),
    .B10 (bo[10]), .B11 (bo[11]), .B12 (bo[12]), .B13 (bo[13]), .B14 (bo[14])
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 1'b0; bus.abort = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0;
  endtask

  // Drives one burst: mode 0 back-to-back, 1 valid on odd cycles, 2 random gaps.
  // Reports observations only; callers compare them against expectations.
  task automatic drive_burst(input word_arr_t w, input int mode, input bit inject,
                             output int done_at, output int done_cnt,
                             output int last_acc, output int cnt_errs);
    int k = 0;
    int cyc;
    int tail = 0;
    bit v;
    done_at = -1; done_cnt = 0; last_acc = -1; cnt_errs = 0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    cyc = 1;
    while (cyc < 400 && tail < 3) begin
      v = 1'b0;
      if (k < 15) begin
        case (mode)
          0:       v = 1'b1;
          1:       v = (cyc % 2) == 1;
          default: v = $urandom_range(0, 2) != 0;
        endcase
        bus.in_valid = v;
        bus.in_data  = v ? w[k] : 16'($urandom);
        if (inject) begin
          bus.start   = 1'b1;
          bus.wr_en   = 1'b1;
          bus.wr_sel  = 4'($urandom_range(0, 15));
          bus.wr_data = 16'($urandom);
        end
        if (bus.load_cnt !== 4'(k) || bus.in_ready !== 1'b1 || bus.busy !== 1'b1) cnt_errs++;
      end else begin
        idle_inputs();
        tail++;
      end
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_at = cyc;
      end
      step();
      if (k < 15 && v) begin
        last_acc = cyc;
        k++;
      end
      cyc++;
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 15; i++) exp_b[i] = '0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL reset in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", bus.done); end
    total++; if (bus.load_cnt !== 4'd0) begin bad++; $display("FAIL reset load_cnt: got %0d want 0", bus.load_cnt); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL reset B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_burst_b2b();
    word_arr_t w;
    int da, dc, la, ce;
    for (int i = 0; i < 15; i++) w[i] = 16'h0101 + 16'(i);
    drive_burst(w, 0, 1'b0, da, dc, la, ce);
    for (int i = 0; i < 15; i++) exp_b[i] = w[i];
    total++; if (dc !== 1) begin bad++; $display("FAIL b2b done_count: got %0d want 1", dc); end
    total++; if (da !== 16) begin bad++; $display("FAIL b2b done_cycle: got %0d want 16", da); end
    total++; if (ce !== 0) begin bad++; $display("FAIL b2b load_cnt_seq: got %0d errors want 0", ce); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL b2b busy_after: got %b want 0", bus.busy); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL b2b B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_burst_toggle();
    word_arr_t w;
    int da, dc, la, ce;
    for (int i = 0; i < 15; i++) w[i] = 16'($urandom);
    drive_burst(w, 1, 1'b0, da, dc, la, ce);
    for (int i = 0; i < 15; i++) exp_b[i] = w[i];
    total++; if (dc !== 1) begin bad++; $display("FAIL toggle done_count: got %0d want 1", dc); end
    total++; if (da !== 30) begin bad++; $display("FAIL toggle done_cycle: got %0d want 30", da); end
    total++; if (ce !== 0) begin bad++; $display("FAIL toggle load_cnt_seq: got %0d errors want 0", ce); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL toggle B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_burst_random_gaps();
    word_arr_t w;
    int da, dc, la, ce;
    for (int i = 0; i < 15; i++) w[i] = 16'($urandom);
    drive_burst(w, 2, 1'b0, da, dc, la, ce);
    for (int i = 0; i < 15; i++) exp_b[i] = w[i];
    total++; if (la < 15) begin bad++; $display("FAIL gaps timeout: last_accept %0d want >=15", la); end
    total++; if (dc !== 1) begin bad++; $display("FAIL gaps done_count: got %0d want 1", dc); end
    total++; if (da !== la + 1) begin bad++; $display("FAIL gaps done_cycle: got %0d want %0d", da, la + 1); end
    total++; if (ce !== 0) begin bad++; $display("FAIL gaps load_cnt_seq: got %0d errors want 0", ce); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL gaps B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_single_write();
    logic [3:0]  s;
    logic [15:0] d;
    idle_inputs();
    for (int n = 0; n < 22; n++) begin
      if (n == 0) begin s = 4'd3; d = 16'hBEEF; end
      else if (n == 1) begin s = 4'd15; d = 16'h1234; end
      else begin s = 4'($urandom_range(0, 15)); d = 16'($urandom); end
      bus.wr_en = (n < 2) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
      bus.wr_sel = s; bus.wr_data = d;
      step();
      if (bus.wr_en && s < 15) exp_b[s] = d;
      for (int i = 0; i < 15; i++) begin
        total++;
        if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL single[%0d] B%0d: got %h want %h", n, i, bo[i], exp_b[i]); end
      end
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    // Abort after 5 accepted words; the start cycle also carries a single write.
    bus.start = 1'b1; bus.wr_en = 1'b1; bus.wr_sel = 4'd9; bus.wr_data = 16'h5A5A;
    step();
    idle_inputs();
    exp_b[9] = 16'h5A5A;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort start_busy: got %b want 1", bus.busy); end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'hA000 + 16'(i);
      step();
      exp_b[i] = 16'hA000 + 16'(i);
    end
    bus.in_valid = 1'b0; bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort busy: got %b want 0", bus.busy); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL abort in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.load_cnt !== 4'd0) begin bad++; $display("FAIL abort load_cnt: got %0d want 0", bus.load_cnt); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort done: got %b want 0", bus.done); end
    step();
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort done_late: got %b want 0", bus.done); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL abort B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
    // Abort coinciding with the third accepted word: that word still lands.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'hC000 + 16'(i); bus.abort = (i == 2);
      step();
      exp_b[i] = 16'hC000 + 16'(i);
    end
    idle_inputs();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort2 busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort2 done: got %b want 0", bus.done); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL abort2 B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_reset_midburst();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 16'($urandom);
      step();
    end
    total++; if (bus.load_cnt !== 4'd7) begin bad++; $display("FAIL midrst pre_cnt: got %0d want 7", bus.load_cnt); end
    bus.in_valid = 1'b1; bus.in_data = 16'hFFFF; rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    for (int i = 0; i < 15; i++) exp_b[i] = '0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL midrst in_ready: got %b want 0", bus.in_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL midrst busy: got %b want 0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL midrst done: got %b want 0", bus.done); end
    total++; if (bus.load_cnt !== 4'd0) begin bad++; $display("FAIL midrst load_cnt: got %0d want 0", bus.load_cnt); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL midrst B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  task automatic test_ignore_in_load();
    word_arr_t w;
    int da, dc, la, ce;
    for (int i = 0; i < 15; i++) w[i] = 16'($urandom);
    drive_burst(w, 0, 1'b1, da, dc, la, ce);
    for (int i = 0; i < 15; i++) exp_b[i] = w[i];
    total++; if (dc !== 1) begin bad++; $display("FAIL ignore done_count: got %0d want 1", dc); end
    total++; if (da !== 16) begin bad++; $display("FAIL ignore done_cycle: got %0d want 16", da); end
    total++; if (ce !== 0) begin bad++; $display("FAIL ignore load_cnt_seq: got %0d errors want 0", ce); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL ignore busy_after: got %b want 0", bus.busy); end
    for (int i = 0; i < 15; i++) begin
      total++;
      if (bo[i] !== exp_b[i]) begin bad++; $display("FAIL ignore B%0d: got %h want %h", i, bo[i], exp_b[i]); end
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_burst_b2b();
    test_burst_toggle();
    test_single_write();
    test_abort();
    test_burst_random_gaps();
    test_reset_midburst();
    test_ignore_in_load();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
